// File: rtl/dt1_lsu.sv
// dt1_lsu: RV32I memory stage -- data bus handshake, lane alignment, MEM/WB register.
// Define DT1_LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of issuing them.
module dt1_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [1:0]  MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  LoadSizeM,
   input  logic        RegWriteM,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        StallM,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUResultW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  RdW,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic        MisalignedM
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, stateNext;
   logic        isStore, isLoad, acc, accBus, misal;
   logic [1:0]  off, sz;
   logic [3:0]  beNow, beQ;
   logic [31:0] shiftW, wdataNow, shiftR, loadExt;
   logic [31:0] addrQ, wdataQ;
   logic        weQ;

   always_comb begin
      isStore = MemWriteM != 2'b00;
      isLoad  = !isStore && ResultSrcM == 2'b01;
      acc     = isStore || ResultSrcM == 2'b01;
      off     = ALUResultM[1:0];
      // sz: 0 byte, 1 half, 2 word
      if (isStore)
         sz = MemWriteM - 2'd1;
      else if (LoadSizeM[1:0] == 2'b00)
         sz = 2'd0;
      else if (LoadSizeM[1:0] == 2'b01)
         sz = 2'd1;
      else
         sz = 2'd2;
`ifdef DT1_LSU_MISALIGN_TRAP_EN
      misal = acc &&
         ((sz == 2'd1 && off[0]) ||
          (sz == 2'd2 && off != 2'b00));
`else
      misal = 1'b0;
`endif
      accBus = acc && !misal;
   end

   always_comb begin
      shiftW = WriteDataM << {off, 3'b000};
      unique case (1'b1)
         sz == 2'd0: begin
            beNow    = 4'b0001 << off;
            wdataNow = {4{WriteDataM[7:0]}};
         end
         sz == 2'd1: begin
            beNow    = 4'b0011 << off;
            wdataNow = off[0] ? shiftW
                              : {2{WriteDataM[15:0]}};
         end
         default: begin
            beNow    = 4'b1111 << off;
            wdataNow = shiftW;
         end
      endcase
   end

   // Bytes above the addressed lane are zero-filled before extension.
   always_comb begin
      shiftR = mem_rdata >> {off, 3'b000};
      unique case (LoadSizeM)
         3'b000:  loadExt = {{24{shiftR[7]}}, shiftR[7:0]};
         3'b001:  loadExt = {{16{shiftR[15]}}, shiftR[15:0]};
         3'b100:  loadExt = {24'h0, shiftR[7:0]};
         3'b101:  loadExt = {16'h0, shiftR[15:0]};
         default: loadExt = shiftR;
      endcase
   end

   always_comb begin
      stateNext = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_be    = 4'h0;
      mem_wdata = 32'h0;
      unique case (state)
         IDLE: begin
            if (accBus) begin
               mem_req   = 1'b1;
               mem_we    = isStore;
               mem_addr  = {ALUResultM[31:2], 2'b00};
               mem_be    = isStore ? beNow : 4'hF;
               mem_wdata = isStore ? wdataNow : 32'h0;
               if (!mem_ready)
                  stateNext = WAIT;
            end
         end
         WAIT: begin
            mem_req   = 1'b1;
            mem_we    = weQ;
            mem_addr  = addrQ;
            mem_be    = beQ;
            mem_wdata = wdataQ;
            if (mem_ready)
               stateNext = IDLE;
         end
      endcase
      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = 32'h0;
         mem_be    = 4'h0;
         mem_wdata = 32'h0;
      end
   end

   assign StallM      = rst_n && accBus && !(mem_req && mem_ready);
   assign MisalignedM = misal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         addrQ  <= 32'h0;
         wdataQ <= 32'h0;
         beQ    <= 4'h0;
         weQ    <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == IDLE && accBus && !mem_ready) begin
            addrQ  <= mem_addr;
            wdataQ <= mem_wdata;
            beQ    <= mem_be;
            weQ    <= mem_we;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ReadDataW  <= 32'h0;
         ALUResultW <= 32'h0;
         PCPlus4W   <= 32'h0;
         RdW        <= 5'h0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
      end else if (StallM) begin
         RdW        <= 5'h0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
      end else begin
         ReadDataW  <= (isLoad && !misal) ? loadExt : 32'h0;
         ALUResultW <= ALUResultM;
         PCPlus4W   <= PCPlus4M;
         RdW        <= misal ? 5'h0 : RdM;
         RegWriteW  <= RegWriteM && !misal;
         ResultSrcW <= misal ? 2'b00 : ResultSrcM;
      end
   end

endmodule

// File: tb/tb_dt1_lsu.sv
// tb_dt1_lsu: randomized scoreboard bench for dt1_lsu.
// Stimulus pushes expected bus/WB behaviour; monitors pop and compare.
module tb_dt1_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [1:0]  MemWriteM, ResultSrcM;
   logic [2:0]  LoadSizeM;
   logic        RegWriteM;
   logic [4:0]  RdM;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        StallM, RegWriteW, MisalignedM;
   logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
   logic [4:0]  RdW;
   logic [1:0]  ResultSrcW;

   always #5 clk = ~clk;

   dt1_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .LoadSizeM(LoadSizeM), .RegWriteM(RegWriteM),
      .RdM(RdM), .PCPlus4M(PCPlus4M),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .StallM(StallM),
      .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
      .PCPlus4W(PCPlus4W), .RdW(RdW),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .MisalignedM(MisalignedM)
   );

   typedef struct {
      logic [31:0] addr, wdata, rdata, pc;
      logic [1:0]  st, rs;
      logic [2:0]  ls;
      logic        rw;
      logic [4:0]  rd;
      int          waits;
   } instr_t;

   typedef struct {
      logic        req, stall, we, mis;
      logic [31:0] addr, lanes;
      logic [3:0]  be;
   } cyc_t;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  rs;
      logic [31:0] alu, pc, rdv;
      int          at;
   } wb_t;

   cyc_t cycQ[$];
   wb_t  wbQ[$];
   cyc_t ce;
   wb_t  we;
   wb_t  lastWb;
   int   nTests = 0;
   int   nFail = 0;
   int   cycNo = 0;

   always @(posedge clk) cycNo <= cycNo + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int nBytes(instr_t i);
      if (i.st == 2'd1) return 1;
      if (i.st == 2'd2) return 2;
      if (i.st == 2'd3) return 4;
      if (i.ls[1:0] == 2'b00) return 1;
      if (i.ls[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit isMem(instr_t i);
      return i.st != 2'd0 || i.rs == 2'd1;
   endfunction

   function automatic bit misModel(instr_t i);
`ifdef DT1_LSU_MISALIGN_TRAP_EN
      return isMem(i) && (int'(i.addr[1:0]) % nBytes(i)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] expBe(instr_t i);
      logic [3:0] b = 4'hF;
      int o = int'(i.addr[1:0]);
      if (i.st != 2'd0)
         for (int k = 0; k < 4; k++)
            b[k] = (k >= o) && (k < o + nBytes(i));
      return b;
   endfunction

   function automatic logic [31:0] expLoad(instr_t i);
      int o = int'(i.addr[1:0]);
      logic [31:0] w = i.rdata >> (8 * o);
      case (i.ls)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] beMask(logic [3:0] b);
      return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

   task automatic driveIdle();
      ALUResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0;
      MemWriteM = 2'b00; ResultSrcM = 2'b00; LoadSizeM = 3'b000;
      RegWriteM = 1'b0; RdM = 5'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic issue(instr_t i);
      bit   mem = isMem(i) && !misModel(i);
      bit   mis = misModel(i);
      bit   ld = i.st == 2'd0 && i.rs == 2'd1;
      int   n = mem ? i.waits : 0;
      cyc_t e;
      wb_t  w;
      for (int c = 0; c <= n; c++) begin
         ALUResultM = i.addr;
         WriteDataM = i.wdata;
         PCPlus4M   = i.pc;
         MemWriteM  = i.st;
         ResultSrcM = i.rs;
         LoadSizeM  = i.ls;
         RegWriteM  = i.rw;
         RdM        = i.rd;
         mem_ready  = mem ? (c == n) : 1'($urandom_range(0, 1));
         mem_rdata  = (c == n) ? i.rdata : $urandom;
         e.req   = mem;
         e.stall = mem && c < n;
         e.we    = i.st != 2'd0;
         e.mis   = mis;
         e.addr  = {i.addr[31:2], 2'b00};
         e.be    = expBe(i);
         e.lanes = i.wdata << (8 * int'(i.addr[1:0]));
         cycQ.push_back(e);
         if (c < n) begin
            w    = lastWb;
            w.rw = 1'b0;
            w.rd = 5'h0;
            w.rs = 2'b00;
         end else begin
            w.rw  = i.rw && !mis;
            w.rd  = mis ? 5'h0 : i.rd;
            w.rs  = mis ? 2'b00 : i.rs;
            w.alu = i.addr;
            w.pc  = i.pc;
            w.rdv = (ld && !mis) ? expLoad(i) : 32'h0;
         end
         w.at = cycNo + 1;
         wbQ.push_back(w);
         lastWb = w;
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (cycQ.size() > 0) begin
         ce = cycQ.pop_front();
         chk("mem_req", 32'(mem_req), 32'(ce.req));
         chk("StallM", 32'(StallM), 32'(ce.stall));
         chk("MisalignedM", 32'(MisalignedM), 32'(ce.mis));
         if (ce.req) begin
            chk("mem_we", 32'(mem_we), 32'(ce.we));
            chk("mem_addr", mem_addr, ce.addr);
            chk("mem_be", 32'(mem_be), 32'(ce.be));
            if (ce.we)
               chk("mem_wdata_lanes", mem_wdata & beMask(ce.be),
                   ce.lanes & beMask(ce.be));
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (wbQ.size() > 0 && wbQ[0].at <= cycNo) begin
         we = wbQ.pop_front();
         if (we.at != cycNo)
            chk("wb_timing", 32'(we.at), 32'(cycNo));
         chk("RegWriteW", 32'(RegWriteW), 32'(we.rw));
         chk("RdW", 32'(RdW), 32'(we.rd));
         chk("ResultSrcW", 32'(ResultSrcW), 32'(we.rs));
         chk("ALUResultW", ALUResultW, we.alu);
         chk("PCPlus4W", PCPlus4W, we.pc);
         chk("ReadDataW", ReadDataW, we.rdv);
      end
   end

   instr_t dir[$];
   instr_t r;

   initial begin
      driveIdle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_StallM", 32'(StallM), 32'h0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
      chk("rst_ReadDataW", ReadDataW, 32'h0);
      chk("rst_ALUResultW", ALUResultW, 32'h0);
      chk("rst_PCPlus4W", PCPlus4W, 32'h0);
      chk("rst_RdW", 32'(RdW), 32'h0);
      rst_n = 1'b1;
      lastWb = '{default: 0};
      @(posedge clk); #1;

      // SW, SB, LB, LBU, slow LW, LH at odd address
      dir.push_back('{32'h100, 32'hDEADBEEF, 32'h0, 32'h4, 2'd3, 2'd0, 3'b010, 1'b0, 5'd0, 0});
      dir.push_back('{32'h203, 32'h000000A5, 32'h0, 32'h8, 2'd1, 2'd0, 3'b000, 1'b0, 5'd0, 0});
      dir.push_back('{32'h11, 32'h0, 32'h00008000, 32'hC, 2'd0, 2'd1, 3'b000, 1'b1, 5'd5, 0});
      dir.push_back('{32'h11, 32'h0, 32'h00008000, 32'h10, 2'd0, 2'd1, 3'b100, 1'b1, 5'd6, 0});
      dir.push_back('{32'h80, 32'h0, 32'h12345678, 32'h14, 2'd0, 2'd1, 3'b010, 1'b1, 5'd7, 3});
      dir.push_back('{32'h101, 32'h0, 32'hCAFEF00D, 32'h18, 2'd0, 2'd1, 3'b001, 1'b1, 5'd8, 1});
      dir.push_back('{32'h101, 32'h0000BEEF, 32'h0, 32'h1C, 2'd2, 2'd0, 3'b000, 1'b1, 5'd9, 2});
      foreach (dir[k]) issue(dir[k]);

      for (int k = 0; k < 400; k++) begin
         r.addr  = $urandom;
         r.wdata = $urandom;
         r.rdata = $urandom;
         r.pc    = $urandom;
         r.st    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         r.rs    = 2'($urandom_range(0, 3));
         r.ls    = 3'($urandom_range(0, 7));
         r.rw    = 1'($urandom_range(0, 1));
         r.rd    = 5'($urandom_range(0, 31));
         r.waits = $urandom_range(0, 3);
         issue(r);
      end

      driveIdle();
      repeat (3) @(posedge clk);
      #1;
      chk("queues_drained", 32'(cycQ.size() + wbQ.size()), 32'h0);

      // reset while a load is parked waiting for the bus
      ALUResultM = 32'h44; ResultSrcM = 2'b01; LoadSizeM = 3'b010;
      RegWriteM = 1'b1; RdM = 5'd3; PCPlus4M = 32'h50;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("wait_mem_req", 32'(mem_req), 32'h1);
      chk("wait_StallM", 32'(StallM), 32'h1);
      chk("wait_mem_addr", mem_addr, 32'h44);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwait_mem_req", 32'(mem_req), 32'h0);
      chk("rstwait_StallM", 32'(StallM), 32'h0);
      chk("rstwait_RegWriteW", 32'(RegWriteW), 32'h0);
      chk("rstwait_ALUResultW", ALUResultW, 32'h0);
      chk("rstwait_PCPlus4W", PCPlus4W, 32'h0);
      @(posedge clk); #1;
      driveIdle();
      rst_n = 1'b1;
      #1;
      chk("idle_after_rst", 32'(mem_req), 32'h0);
      @(posedge clk); #1;
      chk("idle_after_rst2", 32'(mem_req), 32'h0);
      chk("idle_after_rst_stall", 32'(StallM), 32'h0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
